// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus slave port between N requesters.
// Requests are latched, issued one at a time, and answered or timed out.
module sys_bus_arbiter #(
    parameter int N   = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      s_wen,
    input  logic [N-1:0]      s_ren,
    input  logic [N*AW-1:0]   s_addr,
    input  logic [N*DW-1:0]   s_wdata,
    output logic [N*DW-1:0]   s_rdata,
    output logic [N-1:0]      s_ack,
    output logic [N-1:0]      s_err,
    output logic              m_wen,
    output logic              m_ren,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_ack,
    input  logic              m_err,
    output logic              busy
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   pend, req, eff;
    logic [AW-1:0]  lat_addr [N];
    logic [DW-1:0]  lat_wdata [N];
    logic [N-1:0]   lat_we;
    logic [PW-1:0]  ptr, gnt, sel;
    logic           hit, rsp, tmo;
    logic [15:0]    cnt;
    int             idx;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           sel_we;

    assign req = s_wen | s_ren;
    assign eff = pend | req;
    assign rsp = m_ack | m_err;
    assign tmo = (cnt == 16'(TMO - 1));

    // First pending port at or after ptr, wrapping modulo N.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!hit && eff[idx]) begin
                hit = 1'b1;
                sel = PW'(idx);
            end
        end
    end

    // A port captured at this very edge is served from its live inputs.
    always_comb begin
        if (pend[sel]) begin
            sel_addr  = lat_addr[sel];
            sel_wdata = lat_wdata[sel];
            sel_we    = lat_we[sel];
        end else begin
            sel_addr  = s_addr[sel*AW +: AW];
            sel_wdata = s_wdata[sel*DW +: DW];
            sel_we    = s_wen[sel];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hit) state_nxt = BUSY;
            BUSY:    if (rsp) state_nxt = IDLE;
                     else if (tmo) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            lat_we  <= '0;
            ptr     <= '0;
            gnt     <= '0;
            cnt     <= '0;
            s_ack   <= '0;
            s_err   <= '0;
            s_rdata <= '0;
            m_wen   <= 1'b0;
            m_ren   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                lat_addr[i]  <= '0;
                lat_wdata[i] <= '0;
            end
        end else begin
            s_ack <= '0;
            s_err <= '0;
            m_wen <= 1'b0;
            m_ren <= 1'b0;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !pend[i]) begin
                    pend[i]      <= 1'b1;
                    lat_we[i]    <= s_wen[i];
                    lat_addr[i]  <= s_addr[i*AW +: AW];
                    lat_wdata[i] <= s_wdata[i*DW +: DW];
                end
            end
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        m_wen   <= sel_we;
                        m_ren   <= !sel_we;
                        m_addr  <= sel_addr;
                        m_wdata <= sel_wdata;
                        gnt     <= sel;
                        ptr     <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 16'd1;
                    if (rsp) begin
                        s_err[gnt] <= m_err;
                        s_ack[gnt] <= !m_err;
                        s_rdata[gnt*DW +: DW] <= m_rdata;
                        pend[gnt] <= 1'b0;
                        busy      <= 1'b0;
                    end else if (tmo) begin
                        s_err[gnt] <= 1'b1;
                        s_rdata[gnt*DW +: DW] <= '0;
                        pend[gnt] <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shares one system-bus slave port between N system-bus masters (e.g. PS-AXI bridge, debug UART bridge, sequencer).
- Each requester issues single-cycle wen/ren pulses and waits for a one-cycle ack or err.
- The arbiter latches each request, grants round-robin, and issues exactly one transfer downstream at a time.
- It routes the response back to the requester that issued it and times out unanswered transfers with err.

Parameters:
- N, 2, number of requester ports (2..8)
- AW, 32, address width
- DW, 32, data width
- TMO, 255, cycles to wait for slave ack/err before forcing err (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_wen  in  N  per-requester write pulse
- s_ren  in  N  per-requester read pulse
- s_addr  in  N*AW  per-requester address, port i at bits [i*AW +: AW]
- s_wdata  in  N*DW  per-requester write data
- s_rdata  out  N*DW  per-requester read data, valid with s_ack/s_err
- s_ack  out  N  per-requester one-cycle acknowledge
- s_err  out  N  per-requester one-cycle error
- m_wen  out  1  downstream write pulse
- m_ren  out  1  downstream read pulse
- m_addr  out  AW  downstream address
- m_wdata  out  DW  downstream write data
- m_rdata  in  DW  downstream read data
- m_ack  in  1  downstream acknowledge
- m_err  in  1  downstream error
- busy  out  1  transfer outstanding downstream

Behaviour:
- Reset values: all s_ack, s_err, s_rdata, m_wen, m_ren, m_addr, m_wdata, busy = 0. Pending flags cleared, round-robin pointer = 0, timeout counter = 0, state IDLE. Reset mid-transfer drops the transfer silently; no response is returned to the requester.
- Request capture:
  - s_wen[i] or s_ren[i] high at a clk edge sets pend[i] and latches addr, wdata and we (we = s_wen[i]).
  - Both high on the same cycle is treated as a write.
  - A pulse on a port whose pend[i] is already set is ignored; latched data is not overwritten.
- State IDLE:
  - If any pend bit is set (including bits set at this edge), grant the lowest index >= ptr, wrapping modulo N.
  - Next cycle: m_wen or m_ren = 1 for exactly one cycle, with m_addr/m_wdata from the granted latch; busy = 1; go to BUSY; ptr <- grant+1 mod N.
  - Best-case latency: request pulse at edge k gives a downstream pulse in cycle k+1.
- State BUSY:
  - Counter increments each cycle.
  - On m_ack or m_err sampled high: next cycle s_ack[g] or s_err[g] = 1 for one cycle and s_rdata[g] = m_rdata (registered). pend[g] cleared, busy = 0, go to IDLE.
  - If m_ack and m_err are both high, err wins.
  - If the counter reaches TMO with no response: s_err[g] = 1, s_rdata[g] = 0, go to DRAIN.
  - m_addr/m_wdata hold their value until the next grant.
- State DRAIN (one cycle): any m_ack/m_err is discarded; busy = 0; go to IDLE. This prevents a late slave response from being routed to the next grant.
- s_rdata for non-addressed ports holds its last value. At most one s_ack|s_err bit is high per cycle.
- A requester may issue a new pulse in the same cycle it receives s_ack; it is captured normally.
- Fairness: with all N ports continuously pending, grants rotate 0,1,..,N-1,0,... No port waits more than N-1 transfers.

Test Plan:
- Single write, port 0, addr 0x40000010, data 0xDEADBEEF, slave acks 3 cycles after m_wen -> m_wen one cycle at k+1 with matching addr/data; s_ack[0] one cycle after m_ack; busy high from k+1 to the ack cycle.
- Read, port 1, slave returns 0x12345678 -> s_rdata[1] = 0x12345678 with s_ack[1]; s_ack[0] stays 0.
- N=2, both ports pulse writes at the same edge, immediate-ack slave -> port 0 served first, then port 1. Repeat 10 times -> strict alternation.
- Slave never responds, TMO=8 -> s_err[0] pulses 8 cycles after m_ren, s_rdata[0] = 0. A slave ack injected in the DRAIN cycle is not seen on any s_ack.
- Second pulse on port 0 with addr 0x44 while the first (addr 0x40) is still pending -> only one downstream transfer, at addr 0x40.
- rst asserted while BUSY -> next cycle all outputs 0; no s_ack for the dropped transfer; a new request afterwards completes normally.
